// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, frame constants and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK
    } ps2_state_t;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_STOP_IDX  = 9;
    localparam int PS2_MAX_RETRY = 2;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronised clock. Shared with the ps2_keyboard receiver.
module ps2_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic data_sync,
    output logic fall
);

    logic [1:0] raw;
    logic [1:0] sync_bits;
    logic       prev_clk_reg;

    assign raw = {ps2_data_in, ps2_clk_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            // Two-stage synchroniser; resets to the idle-high line level.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    // Previous synchronised clock level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_clk_reg <= 1'b1;
        end else begin
            prev_clk_reg <= sync_bits[0];
        end
    end

    assign fall      = prev_clk_reg & ~sync_bits[0];
    assign data_sync = sync_bits[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// command byte out on device-generated clock falls and samples the ACK bit.
// Optional feature macro: PS2_TX_RETRY_EN (retry on NACK/timeout, up to
// PS2_MAX_RETRY extra attempts with the latched byte).
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_ok,
    output logic       tx_error
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state_reg, state_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic [3:0]       idx_reg, idx_next;
    logic [7:0]       byte_reg, byte_next;
    logic             parity_reg, parity_next;
    logic             clk_oe_reg, clk_oe_next;
    logic             data_oe_reg, data_oe_next;
    logic             done_reg, done_next;
    logic             ack_ok_reg, ack_ok_next;
    logic             error_reg, error_next;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_reg, retry_next;
`endif

    logic data_sync;
    logic fall;

    ps2_edge_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .data_sync   (data_sync),
        .fall        (fall)
    );

    // State and registered outputs; reset releases both lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            idx_reg     <= '0;
            byte_reg    <= '0;
            parity_reg  <= 1'b0;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            done_reg    <= 1'b0;
            ack_ok_reg  <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inh_cnt_reg <= inh_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            idx_reg     <= idx_next;
            byte_reg    <= byte_next;
            parity_reg  <= parity_next;
            clk_oe_reg  <= clk_oe_next;
            data_oe_reg <= data_oe_next;
            done_reg    <= done_next;
            ack_ok_reg  <= ack_ok_next;
            error_reg   <= error_next;
        end
    end

`ifdef PS2_TX_RETRY_EN
    // Attempts already retried for the current command byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_reg <= '0;
        end else begin
            retry_reg <= retry_next;
        end
    end
`endif

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_next   = state_reg;
        inh_cnt_next = inh_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        idx_next     = idx_reg;
        byte_next    = byte_reg;
        parity_next  = parity_reg;
        clk_oe_next  = clk_oe_reg;
        data_oe_next = data_oe_reg;
        done_next    = 1'b0;
        ack_ok_next  = ack_ok_reg;
        error_next   = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_next   = retry_reg;
`endif

        case (state_reg)
            IDLE: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                if (tx_valid) begin
                    byte_next    = tx_data;
                    parity_next  = odd_parity(tx_data);
                    inh_cnt_next = '0;
                    ack_ok_next  = 1'b0;
                    clk_oe_next  = 1'b1;
                    state_next   = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_next   = '0;
`endif
                end
            end

            INHIBIT: begin
                // Clock held low; device clock falls are invisible/ignored here.
                clk_oe_next  = 1'b1;
                data_oe_next = 1'b0;
                if (inh_cnt_reg == INH_LAST) begin
                    data_oe_next = 1'b1;
                    state_next   = RTS;
                end else begin
                    inh_cnt_next = inh_cnt_reg + INH_W'(1);
                end
            end

            RTS: begin
                // Data low is the start bit; release the clock to the device.
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b1;
                idx_next     = '0;
                to_cnt_next  = '0;
                state_next   = SHIFT;
            end

            SHIFT, ACK: begin
                if (fall) begin
                    to_cnt_next = '0;
                    if (state_reg == SHIFT) begin
                        idx_next = idx_reg + 4'd1;
                        if (idx_reg < 4'(PS2_DATA_BITS)) begin
                            data_oe_next = ~byte_reg[idx_reg[2:0]];
                        end else if (idx_reg < 4'(PS2_STOP_IDX)) begin
                            data_oe_next = ~parity_reg;
                        end else begin
                            data_oe_next = 1'b0;
                            state_next   = ACK;
                        end
                    end else begin
`ifdef PS2_TX_RETRY_EN
                        if (data_sync && (retry_reg < 2'(PS2_MAX_RETRY))) begin
                            retry_next   = retry_reg + 2'd1;
                            inh_cnt_next = '0;
                            clk_oe_next  = 1'b1;
                            data_oe_next = 1'b0;
                            state_next   = INHIBIT;
                        end else
`endif
                        begin
                            done_next   = 1'b1;
                            ack_ok_next = ~data_sync;
                            state_next  = IDLE;
                        end
                    end
                end else if (to_cnt_reg == TO_LAST) begin
                    data_oe_next = 1'b0;
                    ack_ok_next  = 1'b0;
`ifdef PS2_TX_RETRY_EN
                    if (retry_reg < 2'(PS2_MAX_RETRY)) begin
                        retry_next   = retry_reg + 2'd1;
                        inh_cnt_next = '0;
                        clk_oe_next  = 1'b1;
                        state_next   = INHIBIT;
                    end else
`endif
                    begin
                        clk_oe_next = 1'b0;
                        error_next  = 1'b1;
                        state_next  = IDLE;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            default: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign tx_ready    = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign tx_done     = done_reg;
    assign tx_ack_ok   = ack_ok_reg;
    assign tx_error    = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device that
// clocks frames, records the data line on rising edges and answers ACK/NACK.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done, tx_ack_ok, tx_error;

    always #5 clk = ~clk;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_ack_ok   (tx_ack_ok),
        .tx_error    (tx_error)
    );

    int errors = 0;
    int checks = 0;

    // Observed activity, sampled on the falling system-clock edge.
    int   cyc = 0, frames = 0, run = 0, rise_pos = 0, last_run = 0, last_rise = 0;
    int   release_cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, both_cnt = 0;
    logic last_ack = 1'b0, prev_clk_oe = 1'b0;
    logic [1:0] err_oe = 2'b00;

    always @(negedge clk) begin : monitor
        int r, rp;
        r  = run;
        rp = rise_pos;
        if (ps2_clk_oe) begin
            if (!prev_clk_oe) begin
                frames <= frames + 1;
                r  = 0;
                rp = 0;
            end
            r = r + 1;
            if (ps2_data_oe && rp == 0) rp = r;
        end else if (prev_clk_oe) begin
            last_run    <= r;
            last_rise   <= rp;
            release_cyc <= cyc;
        end
        run      <= r;
        rise_pos <= rp;
        if (tx_done) begin
            done_cnt <= done_cnt + 1;
            last_ack <= tx_ack_ok;
        end
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            err_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        prev_clk_oe <= ps2_clk_oe;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as seen on device rising edges: start, LSB-first data,
    // odd parity, stop.
    function automatic logic [10:0] frame_model(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device side of one frame. stop_fall > 0 aborts right after that fall.
    task automatic device_frame(input bit ack_low, input int stop_fall,
                                output logic [10:0] bits, output bit ok);
        int n;
        bits = '0;
        ok   = 1'b0;
        n = 0;
        while (ps2_clk_line && n < 2000) begin @(negedge clk); n++; end
        if (ps2_clk_line) return;
        n = 0;
        while (!ps2_clk_line && n < 2000) begin @(negedge clk); n++; end
        if (!ps2_clk_line) return;
        bits[0] = ps2_data_line;
        ok = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            if (i == stop_fall) return;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_line;
            repeat (HALF) @(negedge clk);
        end
        dev_data_low = ack_low;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // One full command transaction with all its comparisons.
    task automatic run_vec(input logic [7:0] b, input bit ack_low, input bit exp_par,
                           input bit exp_ack, input bit poke);
        int d0, e0, f0, n, tries;
        logic [10:0] bits, exp_bits;
        bit ok, all_ok;
        d0 = done_cnt; e0 = err_cnt; f0 = frames;
        exp_bits = frame_model(b);
        @(negedge clk); tx_data = b; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        if (poke) begin
            tx_data = 8'h11; tx_valid = 1'b1;
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
        end
        tries = ack_low ? 1 : ATTEMPTS;
        all_ok = 1'b1;
        bits = '0;
        for (int a = 0; a < tries; a++) begin
            device_frame(ack_low, 0, bits, ok);
            all_ok &= ok;
        end
        n = 0;
        while (done_cnt == d0 && n < 100) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        $display("tx byte=%02h ack_low=%0d bits=%03h done=%0d ack_ok=%0d frames=%0d",
                 b, ack_low, bits, done_cnt - d0, last_ack, frames - f0);
        check("device_saw_frame", 32'(all_ok), 32'd1);
        check("frame_bits", 32'(bits), 32'(exp_bits));
        check("parity_bit", 32'(bits[9]), 32'(exp_par));
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("error_pulses", 32'(err_cnt - e0), 32'd0);
        check("frame_count", 32'(frames - f0), 32'(tries));
        check("ack_ok", 32'(last_ack), 32'(exp_ack));
        check("ready_after", 32'(tx_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        bit         exp_parity;
        bit         exp_ack_ok;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, e0, f0, n;
        logic [10:0] bits, mb;
        bit ok;
        logic [7:0] rb;
        bit rack;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", 32'({tx_done, tx_ack_ok, tx_error}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table vectors; the first also pokes tx_valid while busy
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i].data, vecs[i].ack_low, vecs[i].exp_parity,
                    vecs[i].exp_ack_ok, i == 0);
            if (i == 0) begin
                check("inhibit_len", 32'(last_run), 32'(INH + 1));
                check("rts_position", 32'(last_rise), 32'(INH + 1));
            end
        end

        // Randomised bytes and ACK responses against the frame model
        for (int i = 0; i < 6; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            mb   = frame_model(rb);
            run_vec(rb, rack, mb[9], rack, 1'b0);
        end

        // Timeout: device never clocks
        d0 = done_cnt; e0 = err_cnt; f0 = frames;
        @(negedge clk); tx_data = 8'h3C; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        n = 0;
        while (err_cnt == e0 && n < ATTEMPTS * (TMO + INH + 10) + 50) begin
            @(posedge clk); n++;
        end
        $display("timeout err=%0d delay=%0d frames=%0d", err_cnt - e0, err_cyc - release_cyc, frames - f0);
        check("timeout_error_seen", 32'(err_cnt - e0), 32'd1);
        check("timeout_delay", 32'(err_cyc - release_cyc), 32'(TMO));
        check("timeout_oe", 32'(err_oe), 32'd0);
        check("timeout_frames", 32'(frames - f0), 32'(ATTEMPTS));
        @(negedge clk);
        check("timeout_ready_next", 32'(tx_ready), 32'd1);
        check("timeout_single_pulse", 32'(tx_error), 32'd0);
        check("timeout_no_done", 32'(done_cnt - d0), 32'd0);

        // Reset on the 5th device clock fall
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk); tx_data = 8'h52; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        device_frame(1'b1, 5, bits, ok);
        check("abort_frame_started", 32'(ok), 32'd1);
        #1;
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        $display("reset mid-frame clk_oe=%0d data_oe=%0d", ps2_clk_oe, ps2_data_oe);
        check("async_rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (3) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_no_error", 32'(err_cnt - e0), 32'd0);
        check("rst_ready_again", 32'(tx_ready), 32'd1);
        run_vec(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);

        check("done_error_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the opposite direction of the existing ps2_keyboard receiver.
- Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) using the standard inhibit / request-to-send / device-clocked frame.
- Captures the device ACK bit.
- Sits in top beside ps2_keyboard; its busy output gates the receiver while a frame is in flight.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between consecutive device clock falling edges, counted from clock release (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ps2_clk_in  in  1  raw PS/2 clock line (pad input)
- ps2_data_in  in  1  raw PS/2 data line (pad input)
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (open-drain)
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release (open-drain)
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse; frame finished and ACK sampled
- tx_ack_ok  out  1  valid with tx_done; 1 = device drove ACK low
- tx_error  out  1  one-cycle pulse on timeout; never coincident with tx_done

Behaviour:
- Reset (async): state IDLE, counters 0, ps2_clk_oe = ps2_data_oe = 0 (lines released in the same cycle), tx_ready = 1, busy/tx_done/tx_ack_ok/tx_error = 0.
- Synchronisation: ps2_clk_in and ps2_data_in pass through 2-FF synchronisers. fall = prev_clk & ~clk_sync.
- IDLE:
  - On handshake, latch tx_data and compute parity = ~^tx_data (odd parity).
  - Clear counter; go to INHIBIT.
  - tx_valid while busy is ignored.
- INHIBIT:
  - clk_oe = 1, data_oe = 0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS (one cycle):
  - clk_oe = 1, data_oe = 1; this is the start bit.
  - Next cycle: clk_oe = 0, go to SHIFT with bit index = 0 and timeout counter = 0.
- SHIFT:
  - On fall with idx 0..7: data_oe = ~byte[idx] (LSB first).
  - On fall with idx 8: data_oe = ~parity.
  - On fall with idx 9: data_oe = 0 (stop bit, line released).
  - idx increments on every fall; after idx 9 go to ACK.
  - The data line changes only on fall; the device samples on the rising edge.
- ACK:
  - On the next fall: tx_ack_ok = ~data_sync, pulse tx_done, go to IDLE.
- Timeout:
  - Applies in SHIFT and ACK. The counter resets on every fall.
  - When the counter reaches TIMEOUT_CYCLES-1: release both lines, pulse tx_error, tx_ack_ok = 0, go to IDLE.
- Outputs are registered; tx_done/tx_error assert in the cycle after the deciding event.
- Counter widths are $clog2 of the parameter value (minimum 1).
- Reset asserted mid-frame releases both lines immediately; no tx_done or tx_error is generated.
- A fall during INHIBIT or RTS (device glitch) is ignored.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- Defined:
  - On NACK (ACK bit = 1) or timeout, the FSM re-enters INHIBIT with the latched byte, up to 2 retries.
  - tx_done/tx_error pulse only on final success or after the last failed attempt.
  - tx_ready stays 0 throughout.
- Undefined: single attempt; NACK reports tx_done with tx_ack_ok = 0; timeout reports tx_error.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, RTS, SHIFT, ACK)
  - constants PS2_DATA_BITS = 8, PS2_STOP_IDX = 9, PS2_MAX_RETRY = 2
  - odd-parity function
- One sub-module, ps2_edge_sync: 2-FF synchroniser plus falling-edge detect, shared with ps2_keyboard.

Test Plan:
- Send 0xED; device model clocks at 40 us half-period and drives ACK = 0 → data line sampled on rising edges reads start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulses once with tx_ack_ok = 1.
- Send 0x00, then 0x01 → parity bits 1 and 0 respectively.
- Device holds data high in the ACK slot → tx_done with tx_ack_ok = 0 (macro undefined); with PS2_TX_RETRY_EN, exactly 3 frames are observed, then tx_done with tx_ack_ok = 0.
- No device clocks after release → tx_error exactly TIMEOUT_CYCLES cycles after clk_oe falls; both oe = 0; tx_ready = 1 the next cycle.
- Measure INHIBIT → clk_oe high for exactly INHIBIT_CYCLES+1 cycles, data_oe rising on the last of them; tx_valid pulsed during busy produces no second frame.
- Assert rst on the 5th device clock fall → both oe = 0 asynchronously, no done/error pulse; after release, a new 0xFF frame completes normally.
